// File: rtl/zcrv_wb_pkg.sv
// Shared write-back definitions: grant encodings and the request record
// carried by every source that competes for the register-file write port.
package zcrv_wb_pkg;

  // One-hot grant encodings, bit order {LSU, ALU, MBUF, MBYP}.
  localparam logic [3:0] WB_SRC_NONE = 4'b0000;
  localparam logic [3:0] WB_SRC_LSU  = 4'b1000;
  localparam logic [3:0] WB_SRC_ALU  = 4'b0100;
  localparam logic [3:0] WB_SRC_MBUF = 4'b0010;
  localparam logic [3:0] WB_SRC_MBYP = 4'b0001;

  typedef struct packed {
    logic        vld;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_mdu_fifo.sv
// Small FIFO for finished MDU results. Each slot has a valid bit and an rd
// tag so decode can ask whether a source register is still waiting here.
// Handshake: push_i is honoured only when not full and pop_i only when not
// empty; the owner drives them from the full/empty flags of the same cycle.
module wb_mdu_fifo
  import zcrv_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic [4:0]  push_rd_i,
  input  logic [31:0] push_data_i,
  input  logic        pop_i,
  input  logic [4:0]  query_rd_i,
  output logic        full_o,
  output logic        empty_o,
  output wb_req_t     head_o,
  output logic        hit_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [4:0]       rd_mem_q   [DEPTH];
  logic [31:0]      data_mem_q [DEPTH];

  logic [AW-1:0] wr_idx, rd_idx;
  logic          do_push, do_pop;

  assign wr_idx  = wr_ptr_q[AW-1:0];
  assign rd_idx  = rd_ptr_q[AW-1:0];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign head_o.vld  = ~empty_o;
  assign head_o.rd   = rd_mem_q[rd_idx];
  assign head_o.data = data_mem_q[rd_idx];

  // Pointer and valid-bit next state; push and pop never hit the same slot
  // because push is blocked while full and pop is blocked while empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    if (do_pop) begin
      rd_ptr_d       = rd_ptr_q + PTR_ONE;
      vld_d[rd_idx]  = 1'b0;
    end
    if (do_push) begin
      wr_ptr_d       = wr_ptr_q + PTR_ONE;
      vld_d[wr_idx]  = 1'b1;
    end
  end

  // Pointer and valid-bit state; reset discards every buffered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
    end
  end

  // Payload storage; contents are qualified by vld_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem_q[wr_idx]   <= push_rd_i;
      data_mem_q[wr_idx] <= push_data_i;
    end
  end

  // rd CAM across the valid slots for the decode hazard lookup.
  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (rd_mem_q[i] == query_rd_i)) hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arb.sv
// Register-file write-port arbiter for the commit stage. Picks one of LSU,
// ALU, buffered MDU head or MDU bypass each cycle and registers the winner.
// Handshakes: lsu_vld_i is a one-cycle pulse that must always be taken;
// alu_vld_i is held by idex while stall_req_o=1; mdu_vld_i is held until a
// cycle where mdu_rdy_o=1, at which point the result is either written
// directly (bypass) or enqueued.
module wb_port_arb
  import zcrv_wb_pkg::*;
#(
  parameter int MDU_BUF_DEPTH = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        alu_vld_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  input  logic        lsu_vld_i,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_data_i,
  input  logic        mdu_vld_i,
  input  logic [4:0]  mdu_rd_i,
  input  logic [31:0] mdu_data_i,
  output logic        mdu_rdy_o,
  input  logic [4:0]  query_rd_i,
  output logic        query_hit_o,
  output logic        stall_req_o,
  output logic        rd_en_o,
  output logic [4:0]  rd_index_o,
  output logic [31:0] rd_data_o,
  output logic        inst_finish_o
);

  localparam logic [3:0] STARVE_MAX = STARVE_LIMIT[3:0];

  logic        alu_eff;
  logic        fifo_full, fifo_empty, fifo_hit;
  logic        fifo_push, fifo_pop, forced;
  wb_req_t     head;
  wb_req_t     sel;
  logic [3:0]  grant;

  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        rd_en_q, rd_en_d;
  logic [4:0]  rd_index_q, rd_index_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        inst_finish_q, inst_finish_d;

  // A flushed ALU result is squashed before it can compete.
  assign alu_eff = alu_vld_i & ~flush_i;
  // The head takes priority over ALU once it has waited long enough.
  assign forced  = ~fifo_empty && (starve_cnt_q == STARVE_MAX);

  // Grant selection: LSU > ALU (unless forced) > FIFO head > MDU bypass.
  always_comb begin
    grant = WB_SRC_NONE;
    sel   = '0;
    if (lsu_vld_i) begin
      grant = WB_SRC_LSU;
      sel   = '{vld: 1'b1, rd: lsu_rd_i, data: lsu_data_i};
    end else if (alu_eff && !forced) begin
      grant = WB_SRC_ALU;
      sel   = '{vld: 1'b1, rd: alu_rd_i, data: alu_data_i};
    end else if (!fifo_empty) begin
      grant = WB_SRC_MBUF;
      sel   = head;
    end else if (mdu_vld_i) begin
      grant = WB_SRC_MBYP;
      sel   = '{vld: 1'b1, rd: mdu_rd_i, data: mdu_data_i};
    end
  end

  // Ready depends only on fullness, so a slot freed by a pop this cycle
  // is not offered to the MDU until the next one.
  assign mdu_rdy_o   = ~fifo_full;
  assign fifo_pop    = (grant == WB_SRC_MBUF);
  assign fifo_push   = mdu_vld_i & ~fifo_full & (grant != WB_SRC_MBYP);
  assign stall_req_o = alu_eff & (grant != WB_SRC_ALU);
  assign query_hit_o = (query_rd_i != 5'd0) &&
                       (fifo_hit || (mdu_vld_i && (mdu_rd_i == query_rd_i)));

  wb_mdu_fifo #(.DEPTH(MDU_BUF_DEPTH)) u_mdu_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_rd_i   (mdu_rd_i),
    .push_data_i (mdu_data_i),
    .pop_i       (fifo_pop),
    .query_rd_i  (query_rd_i),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head),
    .hit_o       (fifo_hit)
  );

  // Starvation counter and write-port next state.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || fifo_pop) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
    rd_en_d       = sel.vld && (sel.rd != 5'd0);
    inst_finish_d = sel.vld;
    rd_index_d    = sel.vld ? sel.rd   : rd_index_q;
    rd_data_d     = sel.vld ? sel.data : rd_data_q;
  end

  // Registered write port, retire pulse and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q  <= 4'd0;
      rd_en_q       <= 1'b0;
      rd_index_q    <= 5'd0;
      rd_data_q     <= 32'd0;
      inst_finish_q <= 1'b0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      rd_en_q       <= rd_en_d;
      rd_index_q    <= rd_index_d;
      rd_data_q     <= rd_data_d;
      inst_finish_q <= inst_finish_d;
    end
  end

  assign rd_en_o       = rd_en_q;
  assign rd_index_o    = rd_index_q;
  assign rd_data_o     = rd_data_q;
  assign inst_finish_o = inst_finish_q;

endmodule

// File: tb/tb_wb_port_arb.sv
// Directed bench for wb_port_arb: a per-cycle vector table plus hand-written
// sequences for starvation and asynchronous reset.
module tb_wb_port_arb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        flush_i, alu_vld_i, lsu_vld_i, mdu_vld_i;
  logic [4:0]  alu_rd_i, lsu_rd_i, mdu_rd_i, query_rd_i;
  logic [31:0] alu_data_i, lsu_data_i, mdu_data_i;
  logic        mdu_rdy_o, query_hit_o, stall_req_o, rd_en_o, inst_finish_o;
  logic [4:0]  rd_index_o;
  logic [31:0] rd_data_o;

  wb_port_arb #(.MDU_BUF_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .alu_vld_i     (alu_vld_i),
    .alu_rd_i      (alu_rd_i),
    .alu_data_i    (alu_data_i),
    .lsu_vld_i     (lsu_vld_i),
    .lsu_rd_i      (lsu_rd_i),
    .lsu_data_i    (lsu_data_i),
    .mdu_vld_i     (mdu_vld_i),
    .mdu_rd_i      (mdu_rd_i),
    .mdu_data_i    (mdu_data_i),
    .mdu_rdy_o     (mdu_rdy_o),
    .query_rd_i    (query_rd_i),
    .query_hit_o   (query_hit_o),
    .stall_req_o   (stall_req_o),
    .rd_en_o       (rd_en_o),
    .rd_index_o    (rd_index_o),
    .rd_data_o     (rd_data_o),
    .inst_finish_o (inst_finish_o)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [36:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        flush, av, lv, mv;
    logic [4:0]  ard, lrd, mrd, qrd;
    logic [31:0] adat, ldat, mdat;
    logic        e_stall, e_rdy, e_hit;
    logic        e_en, e_fin;
    logic [4:0]  e_idx;
    logic [31:0] e_dat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic flush,
                     input logic av, input logic [4:0] ard, input logic [31:0] adat,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                     input logic [4:0] qrd,
                     input logic e_stall, input logic e_rdy, input logic e_hit,
                     input logic e_en, input logic [4:0] e_idx, input logic [31:0] e_dat,
                     input logic e_fin);
    vec_t v;
    v.flush = flush; v.av = av; v.ard = ard; v.adat = adat;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat;
    v.mv = mv; v.mrd = mrd; v.mdat = mdat; v.qrd = qrd;
    v.e_stall = e_stall; v.e_rdy = e_rdy; v.e_hit = e_hit;
    v.e_en = e_en; v.e_idx = e_idx; v.e_dat = e_dat; v.e_fin = e_fin;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic idle_inputs();
    flush_i = 0; alu_vld_i = 0; lsu_vld_i = 0; mdu_vld_i = 0;
    alu_rd_i = 0; lsu_rd_i = 0; mdu_rd_i = 0; query_rd_i = 0;
    alu_data_i = 0; lsu_data_i = 0; mdu_data_i = 0;
  endtask

  task automatic apply(input vec_t v);
    flush_i = v.flush;
    alu_vld_i = v.av; alu_rd_i = v.ard; alu_data_i = v.adat;
    lsu_vld_i = v.lv; lsu_rd_i = v.lrd; lsu_data_i = v.ldat;
    mdu_vld_i = v.mv; mdu_rd_i = v.mrd; mdu_data_i = v.mdat;
    query_rd_i = v.qrd;
  endtask

  initial begin
    int alu_idx;
    logic [36:0] exp_w;

    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset rd_en",    rd_en_o,       0);
    chk("reset rd_index", rd_index_o,    0);
    chk("reset rd_data",  rd_data_o,     0);
    chk("reset finish",   inst_finish_o, 0);
    chk("reset stall",    stall_req_o,   0);
    chk("reset mdu_rdy",  mdu_rdy_o,     1);
    chk("reset hit",      query_hit_o,   0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // fl  av ard adat           lv lrd ldat           mv mrd mdat          q   st rdy hit en idx dat            fin
    // ALU alone
    add(0, 1, 5, 32'h1234,       0, 0, 0,              0, 0, 0,             0,  0, 1, 0,  1, 5, 32'h1234,       1);
    add(0, 0, 0, 0,              0, 0, 0,              0, 0, 0,             0,  0, 1, 0,  0, 0, 0,              0);
    // LSU beats ALU, ALU follows
    add(0, 1, 4, 32'h44,         1, 3, 32'hAAAA0003,   0, 0, 0,             0,  1, 1, 0,  1, 3, 32'hAAAA0003,   1);
    add(0, 1, 4, 32'h44,         0, 0, 0,              0, 0, 0,             0,  0, 1, 0,  1, 4, 32'h44,         1);
    // three MDU finishes behind continuous LSU: 7,8 enqueue, 9 waits
    add(0, 0, 0, 0,              1, 10, 32'hA0,        1, 7, 32'h70,        7,  0, 1, 1,  1, 10, 32'hA0,        1);
    add(0, 0, 0, 0,              1, 11, 32'hB0,        1, 8, 32'h80,        8,  0, 1, 1,  1, 11, 32'hB0,        1);
    add(0, 0, 0, 0,              1, 12, 32'hC0,        1, 9, 32'h90,        7,  0, 0, 1,  1, 12, 32'hC0,        1);
    add(0, 0, 0, 0,              1, 13, 32'hD0,        1, 9, 32'h90,        9,  0, 0, 1,  1, 13, 32'hD0,        1);
    // pop while full: no same-cycle reuse, then 9 enqueues behind 8
    add(0, 0, 0, 0,              0, 0, 0,              1, 9, 32'h90,        9,  0, 0, 1,  1, 7, 32'h70,         1);
    add(0, 0, 0, 0,              0, 0, 0,              1, 9, 32'h90,        8,  0, 1, 1,  1, 8, 32'h80,         1);
    add(0, 0, 0, 0,              0, 0, 0,              0, 0, 0,             9,  0, 1, 1,  1, 9, 32'h90,         1);
    add(0, 0, 0, 0,              0, 0, 0,              0, 0, 0,             9,  0, 1, 0,  0, 0, 0,              0);
    // flush with FIFO holding rd 9
    add(0, 0, 0, 0,              1, 14, 32'hE0,        1, 9, 32'h99,        0,  0, 1, 0,  1, 14, 32'hE0,        1);
    add(1, 1, 6, 32'h66,         0, 0, 0,              0, 0, 0,             9,  0, 1, 1,  1, 9, 32'h99,         1);
    add(0, 0, 0, 0,              0, 0, 0,              0, 0, 0,             6,  0, 1, 0,  0, 0, 0,              0);
    // rd 0 handling and bypass
    add(0, 1, 0, 32'hDEAD,       0, 0, 0,              0, 0, 0,             0,  0, 1, 0,  0, 0, 0,              1);
    add(0, 0, 0, 0,              0, 0, 0,              1, 12, 32'hC,        12, 0, 1, 1,  1, 12, 32'hC,         1);
    add(0, 0, 0, 0,              0, 0, 0,              1, 0, 32'h5,         0,  0, 1, 0,  0, 0, 0,              1);
    add(0, 1, 1, 32'h1,          1, 0, 32'h77,         0, 0, 0,             0,  1, 1, 0,  0, 0, 0,              1);
    add(0, 1, 1, 32'h1,          0, 0, 0,              0, 0, 0,             0,  0, 1, 0,  1, 1, 32'h1,          1);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("v%0d stall", i),   stall_req_o, vecs[i].e_stall);
      chk($sformatf("v%0d mdu_rdy", i), mdu_rdy_o,   vecs[i].e_rdy);
      chk($sformatf("v%0d hit", i),     query_hit_o, vecs[i].e_hit);
      @(posedge clk); #1;
      chk($sformatf("v%0d rd_en", i),   rd_en_o,       vecs[i].e_en);
      chk($sformatf("v%0d finish", i),  inst_finish_o, vecs[i].e_fin);
      if (vecs[i].e_en) begin
        chk($sformatf("v%0d rd_index", i), rd_index_o, vecs[i].e_idx);
        chk($sformatf("v%0d rd_data", i),  rd_data_o,  vecs[i].e_dat);
      end
    end
    idle_inputs();

    // Starvation: MDU rd 7 buffered behind six ALU results; forced after 4 waits.
    for (int i = 0; i < 5; i++) exp_q.push_back({5'(20 + i), 32'(100 + i)});
    exp_q.push_back({5'd7, 32'h7777});
    exp_q.push_back({5'd25, 32'd105});
    alu_idx = 0;
    for (int c = 0; c < 7; c++) begin
      alu_vld_i = 1; alu_rd_i = 5'(20 + alu_idx); alu_data_i = 32'(100 + alu_idx);
      mdu_vld_i = (c == 0); mdu_rd_i = 7; mdu_data_i = 32'h7777;
      query_rd_i = 7;
      #1;
      chk($sformatf("starve c%0d stall", c), stall_req_o, (c == 5));
      chk($sformatf("starve c%0d hit", c),   query_hit_o, (c <= 5));
      if (c == 0) chk("starve enqueue rdy", mdu_rdy_o, 1);
      if (c != 5) alu_idx++;
      @(posedge clk); #1;
      exp_w = exp_q.pop_front();
      chk($sformatf("starve c%0d rd_en", c), rd_en_o, 1);
      chk($sformatf("starve c%0d write", c), {rd_index_o, rd_data_o}, exp_w);
    end
    idle_inputs();
    @(posedge clk); #1;
    chk("starve drained", rd_en_o, 0);

    // Reset while FIFO is full.
    for (int c = 0; c < 3; c++) begin
      lsu_vld_i = 1; lsu_rd_i = 5'(15 + c); lsu_data_i = 32'(200 + c);
      mdu_vld_i = 1; mdu_rd_i = 5'(7 + c); mdu_data_i = 32'(300 + c);
      #1;
      if (c == 2) chk("fill rdy low", mdu_rdy_o, 0);
      @(posedge clk); #1;
    end
    chk("fill last write", {rd_index_o, rd_data_o}, {5'd17, 32'd202});
    idle_inputs();
    query_rd_i = 7;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst rd_en",    rd_en_o,       0);
    chk("async rst rd_index", rd_index_o,    0);
    chk("async rst rd_data",  rd_data_o,     0);
    chk("async rst finish",   inst_finish_o, 0);
    chk("async rst mdu_rdy",  mdu_rdy_o,     1);
    chk("async rst hit",      query_hit_o,   0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst no write",  inst_finish_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
